// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: format encodings and the immediate extension function shared by
// the imm_gen_pipe slice.
// Build option: define IMM_GEN_CSR_UIMM_EN to make format code 101 legal. It then
// yields the zero-extended CSR uimm field instr[19:15]. Without it, 101 is
// illegal like 110 and 111.
package imm_gen_pkg;

    // Widest supported datapath. extend_imm works at this width, and each
    // instance truncates the result to its own XLEN. Every sign extension
    // replicates bit 31, so the low 32 bits are identical for both XLEN values.
    localparam int XLEN_MAX = 64;

    // Immediate format select as decoded upstream. Codes 110 and 111 are never
    // legal.
    typedef enum logic [2:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b001,
        IMM_B   = 3'b010,
        IMM_J   = 3'b011,
        IMM_U   = 3'b100,
        IMM_CSR = 3'b101
    } imm_src_e;

    // Result of one extension: the widest immediate plus the illegal-format flag.
    // The buffered entry type (imm, tag, illegal) depends on XLEN and TAG_W, so it
    // is declared as a typedef inside imm_gen_pipe.
    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        logic                illegal;
    } ext_res_t;

    // Build the immediate for one instruction. Unsupported codes return zero with
    // illegal set, so an X never reaches the datapath.
    function automatic ext_res_t extend_imm(input logic [31:7] instr,
                                            input logic [2:0]  src);
        ext_res_t res;
        res.imm     = '0;
        res.illegal = 1'b0;
        case (src)
            IMM_I:   res.imm = {{52{instr[31]}}, instr[31:20]};
            IMM_S:   res.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   res.imm = {{51{instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0};
            IMM_J:   res.imm = {{43{instr[31]}}, instr[31], instr[19:12],
                                instr[20], instr[30:21], 1'b0};
            IMM_U:   res.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
`ifdef IMM_GEN_CSR_UIMM_EN
            IMM_CSR: res.imm = {59'b0, instr[19:15]};
`endif
            default: res.illegal = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: decode-side and execute-side handshakes of imm_gen_pipe,
// plus the flush control and occupancy status.
// slave is the immediate generator. master is the surrounding pipeline.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) ();

    localparam int CNT_W = $clog2(DEPTH + 1);

    // Pipeline control
    logic             flush;

    // Decode side
    logic             in_valid;
    logic             in_ready;
    logic [31:7]      in_instr;
    logic [2:0]       in_imm_src;
    logic [TAG_W-1:0] in_tag;

    // Execute side
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    // Status
    logic [CNT_W-1:0] count;

    modport slave (
        input  flush,
        input  in_valid, in_instr, in_imm_src, in_tag,
        output in_ready,
        output out_valid, out_imm, out_tag, out_illegal,
        input  out_ready,
        output count
    );

    modport master (
        output flush,
        output in_valid, in_instr, in_imm_src, in_tag,
        input  in_ready,
        input  out_valid, out_imm, out_tag, out_illegal,
        output out_ready,
        input  count
    );

endinterface

// File: rtl/imm_fifo.sv
// imm_fifo: generic synchronous FIFO with DEPTH entries (a power of two, at
// least 2). It has an occupancy count, a synchronous flush that takes priority
// over push and pop, and an asynchronous active-low reset.
// The head entry is always visible on rd_data. full and empty come only from
// registered state, so no ready signal has a combinational path to another.
module imm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // full and empty come from the registered count only.
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A flush cancels any same-cycle transfer in either direction.
    assign push = wr_en && !full  && !flush;
    assign pop  = rd_en && !empty && !flush;

    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy update. DEPTH is a power of two, so the pointers
    // wrap naturally.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and simulation ordering matches the synthesized hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage, written at the tail on push.
    // NOTE: the storage is reset (cheap at this depth) because the head entry
    // drives the outputs directly, and those must read as zero after reset
    // rather than as uninitialised contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator between decode and execute.
// Each accepted instruction is extended combinationally and written into an
// in-order buffer together with its tag and an illegal-format flag. Execute
// consumes entries from the head of that buffer.
// Build option: IMM_GEN_CSR_UIMM_EN enables format code 101 (CSR uimm).
// XLEN must be 32 or 64. DEPTH must be a power of two, at least 2.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    imm_gen_pipe_if.slave bus
);

    // One buffered result. Its widths depend on this instance's parameters.
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } imm_entry_t;

    ext_res_t   ext;
    imm_entry_t wr_entry;
    imm_entry_t rd_entry;
    logic       fifo_full;
    logic       fifo_empty;

    // Extend the incoming instruction and pack it with its tag for the buffer.
    // NOTE: every variable driven here is assigned on every path (the function
    // sets its own defaults first), so no latch can be inferred.
    always_comb begin
        ext              = extend_imm(bus.in_instr, bus.in_imm_src);
        wr_entry.imm     = XLEN'(ext.imm);
        wr_entry.tag     = bus.in_tag;
        wr_entry.illegal = ext.illegal;
    end

    // The buffer decides acceptance itself. in_valid and out_ready are passed
    // through unqualified, and it refuses a push when full and a pop when empty.
    imm_fifo #(
        .WIDTH ($bits(imm_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (bus.flush),
        .wr_en   (bus.in_valid),
        .wr_data (wr_entry),
        .rd_en   (bus.out_ready),
        .rd_data (rd_entry),
        .count   (bus.count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // in_ready depends only on the registered occupancy. A pop in a full cycle
    // reopens the input on the following cycle, never on the same one.
    assign bus.in_ready    = !fifo_full;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_imm     = rd_entry.imm;
    assign bus.out_tag     = rd_entry.tag;
    assign bus.out_illegal = rd_entry.illegal;

endmodule
